braun_mac_accum: RTL
====================

Name: braun_mac_accum

Overview:
- Sequential accumulate stage wrapped around the team's existing combinational 4x4 Braun array multiplier (ports x, y, p).
- Accepts unsigned 4-bit operand pairs over a valid/ready stream and registers each pair into an operand stage that drives the multiplier.
- Accumulates the 8-bit products over a frame and emits one frame sum per frame on an output valid/ready stream.
- Sits between the operand source and any sum consumer; the bare multiplier gains clocking, back-pressure and framing.

Parameters:
- FRAME_LEN, 4: maximum beats per frame, legal range 1..15.
- ACC_W, 12: accumulator and out_sum width, minimum 8; sums wrap modulo 2^ACC_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame abort.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_x  in  4  multiplicand.
- in_y  in  4  multiplier.
- in_last  in  1  closes the frame on this beat.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  sum of the frame's products.
- out_count  out  4  number of beats in the frame.
- out_ovf  out  1  accumulation wrapped at least once in this frame.

Behaviour:
- Reset (async, rst_n=0):
  - in_ready=1; out_valid=0; out_sum=0; out_count=0; out_ovf=0.
  - Accumulator, beat counter and operand stage cleared; state S_IDLE.
  - On deassertion, operation starts at the next clk edge.
- Reset mid-frame discards all partial state with no output.
- Operand stage:
  - On an accept edge, register x_q, y_q, v1=1 and last1.
  - last1 = in_last || (beat_cnt == FRAME_LEN-1).
  - Otherwise v1=0.
  - Multiplier is driven only from x_q/y_q. p is 8 bits, zero-extended to ACC_W.
- Accumulate stage, when v1=1:
  - sum_n = acc + p, computed at ACC_W+1 bits. The carry out sets the sticky ovf bit; the result wraps.
  - If last1=0: acc <= sum_n and cnt++.
  - If last1=1: out_sum <= sum_n[ACC_W-1:0], out_count <= cnt+1, out_ovf <= ovf|carry, out_valid <= 1. Then acc, cnt and ovf are cleared.
- Latency: last beat accepted in cycle T gives out_valid=1 in cycle T+2. Throughput is 1 beat/cycle within a frame.
- FSM states:
  - S_IDLE (no beats yet): first accept -> S_ACC; if that beat is the last, go to S_DRAIN instead.
  - S_ACC: accept of a last beat -> S_DRAIN.
  - S_DRAIN (last beat in operand stage): unconditional -> S_HOLD, with out_valid set.
  - S_HOLD: out_valid && out_ready -> S_IDLE.
- in_ready is registered and equals 1 only in S_IDLE and S_ACC. It drops the cycle after the last beat is accepted and returns the cycle after the output handshake. No beat is dropped or duplicated while in_valid is held.
- Output hold: out_sum, out_count and out_ovf stay stable while out_valid=1 and out_ready=0. out_valid falls the cycle after the handshake.
- clear has priority over all events, including a simultaneous accept or handshake:
  - Drops the operand stage and zeroes acc, cnt and ovf.
  - Sets out_valid=0, in_ready=1, state S_IDLE.
  - A beat presented in the clear cycle is not accepted.
- FRAME_LEN=1: every beat is a frame.
- in_last on the FRAME_LEN-th beat: a single frame close, no double close.
- Products of 0 still count as beats.

Decomposition:
- Shared package braun_pkg holds:
  - constants OPW=4 and PRODW=8;
  - the state enum {S_IDLE, S_ACC, S_DRAIN, S_HOLD};
  - an elaboration-time check function enforcing ACC_W>=8 and 1<=FRAME_LEN<=15.
- One sub-module: a single instance of the existing 4x4 Braun array multiplier, connected to x_q, y_q, p.
- All registers and the FSM live in braun_mac_accum. No other sub-modules.

Test Plan:
1. Basic frame: FRAME_LEN=4, ACC_W=12, out_ready=1; beats (3,5), (15,15), (0,9), (7,2) back-to-back.
   Required: out_sum=254, out_count=4, out_ovf=0, out_valid two cycles after the 4th accept.
2. Early close: beats (15,15), then (15,15) with in_last=1.
   Required: out_sum=450, out_count=2; the next frame starts from acc=0.
3. Back-pressure: out_ready=0 for 5 cycles after frame 1 while in_valid is held with (1,1).
   Required: in_ready=0 throughout and out_sum stable at 254. After the handshake, the next frame's first beat is accepted one cycle later.
4. Wrap: ACC_W=8; beats (15,15), (15,15) with in_last=1.
   Required: out_sum=194, out_count=2, out_ovf=1.
5. Abort paths:
   - clear pulsed after 2 beats, then beat (2,3) with in_last=1: out_sum=6, out_count=1.
   - rst_n pulsed low mid-frame: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/braun_mac_accum_pkg.sv
// Shared constants, FSM state type and parameter legality check for the Braun MAC accumulator.
package braun_pkg;

  localparam int OPW   = 4;
  localparam int PRODW = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_HOLD
  } state_t;

  function automatic bit params_ok(input int acc_w, input int frame_len);
    return (acc_w >= PRODW) && (frame_len >= 1) && (frame_len <= 15);
  endfunction

endpackage

// File: rtl/braun_mac_accum_if.sv
// Operand-in and frame-sum-out valid/ready streams of the MAC accumulator.
interface braun_mac_accum_if #(
  parameter int ACC_W = 12
);
  import braun_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_x;
  logic [OPW-1:0]   in_y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [3:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/braun_mac_accum_mult.sv
// Combinational 4x4 unsigned Braun array multiplier: carry-save rows of full adders, ripple final row.
module braun_mult4
  import braun_pkg::*;
(
  input  logic [OPW-1:0]   x,
  input  logic [OPW-1:0]   y,
  output logic [PRODW-1:0] p
);

  logic [OPW-1:0] w_s [OPW];
  logic [OPW-1:0] w_c [OPW];
  logic [OPW-1:0] w_sh;
  logic [1:0]     w_fa;

  // Row i cell j has weight i+j; sums from the row above are shifted down one column.
  always_comb begin
    w_s[0] = x & {OPW{y[0]}};
    w_c[0] = '0;
    w_sh   = '0;
    w_fa   = '0;
    for (int i = 1; i < OPW; i++) begin
      w_sh = {1'b0, w_s[i-1][OPW-1:1]};
      for (int j = 0; j < OPW; j++) begin
        w_fa = {1'b0, x[j] & y[i]} + {1'b0, w_sh[j]} + {1'b0, w_c[i-1][j]};
        w_s[i][j] = w_fa[0];
        w_c[i][j] = w_fa[1];
      end
    end
    for (int i = 0; i < OPW; i++) begin
      p[i] = w_s[i][0];
    end
    p[PRODW-1:OPW] = {1'b0, w_s[OPW-1][OPW-1:1]} + w_c[OPW-1];
  end

endmodule

// File: rtl/braun_mac_accum.sv
// Frame accumulator around the Braun multiplier; last beat accepted in cycle T gives out_valid in T+2.
// in_ready drops after a frame's last beat and returns the cycle after the result handshake.
module braun_mac_accum
  import braun_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  braun_mac_accum_if.slave  s_if
);

  localparam int         SUMW     = ACC_W + 1;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  if (!params_ok(ACC_W, FRAME_LEN)) begin : g_param_chk
    $error("braun_mac_accum: ACC_W must be >= 8 and FRAME_LEN within 1..15");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OPW-1:0]   r_x_q;
  logic [OPW-1:0]   r_y_q;
  logic             r_v1;
  logic             r_last1;
  logic [3:0]       r_beat_cnt;
  logic [3:0]       r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [3:0]       r_out_count;
  logic             r_out_ovf;
  logic [PRODW-1:0] w_p;
  logic [SUMW-1:0]  w_sum_n;
  logic             w_accept;
  logic             w_last_in;
  logic             w_hs;

  braun_mult4 u_mult (
    .x (r_x_q),
    .y (r_y_q),
    .p (w_p)
  );

  assign w_accept  = s_if.in_valid && r_in_ready && !clear;
  assign w_last_in = s_if.in_last || (r_beat_cnt == LAST_IDX);
  assign w_hs      = r_out_valid && s_if.out_ready;
  assign w_sum_n   = {1'b0, r_acc} + SUMW'(w_p);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_last_in ? S_DRAIN : S_ACC;
      S_ACC:   if (w_accept && w_last_in) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_HOLD;
      S_HOLD:  if (w_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x_q       <= '0;
      r_y_q       <= '0;
      r_v1        <= 1'b0;
      r_last1     <= 1'b0;
      r_beat_cnt  <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACC);
      r_v1       <= w_accept;
      if (w_accept) begin
        r_x_q      <= s_if.in_x;
        r_y_q      <= s_if.in_y;
        r_last1    <= w_last_in;
        r_beat_cnt <= w_last_in ? 4'd0 : r_beat_cnt + 4'd1;
      end
      if (w_hs) r_out_valid <= 1'b0;
      if (r_v1) begin
        if (r_last1) begin
          r_out_sum   <= w_sum_n[ACC_W-1:0];
          r_out_count <= r_cnt + 4'd1;
          r_out_ovf   <= r_ovf | w_sum_n[ACC_W];
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc <= w_sum_n[ACC_W-1:0];
          r_cnt <= r_cnt + 4'd1;
          r_ovf <= r_ovf | w_sum_n[ACC_W];
        end
      end
      // Abort overrides any accept, accumulate or handshake in the same cycle.
      if (clear) begin
        r_v1        <= 1'b0;
        r_beat_cnt  <= '0;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign s_if.in_ready  = r_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_sum   = r_out_sum;
  assign s_if.out_count = r_out_count;
  assign s_if.out_ovf   = r_out_ovf;

endmodule
